// File: rtl/axis_pkt_len_tagger.sv
// AXI4-Stream pass-through that tags each packet with its byte length.
// Beats flow through a registered skid buffer; lengths go to a 2-deep FIFO.
//
// Ports:
//   aclk, areset           clock, synchronous active-high reset
//   s_axis_t{data,keep,last,valid,ready}   input beat stream
//   m_axis_t{data,keep,last,valid,ready}   output beat stream (registered)
//   m_len_t{data,user,valid,ready}         per-packet length channel
//     m_len_tuser[0] = keep error, m_len_tuser[1] = length overflow
module axis_pkt_len_tagger #(
  parameter int DATA_BYTES = 4,
  parameter int LEN_W      = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [8*DATA_BYTES-1:0] s_axis_tdata,
  input  logic [DATA_BYTES-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [8*DATA_BYTES-1:0] m_axis_tdata,
  output logic [DATA_BYTES-1:0]   m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [LEN_W-1:0]        m_len_tdata,
  output logic [1:0]              m_len_tuser,
  output logic                    m_len_tvalid,
  input  logic                    m_len_tready
);

  localparam int DW = 8 * DATA_BYTES;
  localparam int BW = DW + DATA_BYTES + 1;
  localparam int EW = LEN_W + 2;

  localparam logic [LEN_W:0] LEN_MAX = {1'b0, {LEN_W{1'b1}}};
  localparam logic [DATA_BYTES-1:0] KEEP_ALL = '1;

  function automatic logic [LEN_W:0] popcnt(
    input logic [DATA_BYTES-1:0] k
  );
    logic [LEN_W:0] n;
    n = '0;
    for (int i = 0; i < DATA_BYTES; i++)
      n = n + {{LEN_W{1'b0}}, k[i]};
    return n;
  endfunction

  // Beat bundle: {tdata, tkeep, tlast}
  logic [BW-1:0] in_beat;
  logic [BW-1:0] main_q, main_d;
  logic [BW-1:0] skid_q, skid_d;
  logic          main_vld_q, main_vld_d;
  logic          skid_vld_q, skid_vld_d;
  logic          rdy_q, rdy_d;

  logic [LEN_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  // Length FIFO: head entry drives the outputs, tail is the second slot.
  // Entry layout: {ovf, err, length}
  logic [EW-1:0] head_q, head_d;
  logic [EW-1:0] tail_q, tail_d;
  logic          head_vld_q, head_vld_d;
  logic          tail_vld_q, tail_vld_d;

  logic                  accept;
  logic                  main_free;
  logic                  push;
  logic                  pop;
  logic [LEN_W:0]        sum;
  logic                  sum_ovf;
  logic [LEN_W-1:0]      len_sat;
  logic [DATA_BYTES-1:0] keep_inc;
  logic                  keep_bad;
  logic [EW-1:0]         new_ent;

  assign in_beat   = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
  assign accept    = s_axis_tvalid && rdy_q;
  assign main_free = m_axis_tready || !main_vld_q;
  assign push      = accept && s_axis_tlast;
  assign pop       = head_vld_q && m_len_tready;

  // Saturating byte count; once pinned at max it stays there until tlast.
  assign sum     = {1'b0, acc_q} + popcnt(s_axis_tkeep);
  assign sum_ovf = sum > LEN_MAX;
  assign len_sat = sum_ovf ? {LEN_W{1'b1}} : sum[LEN_W-1:0];

  // A last-beat keep is legal when it is 0..01..1: adding one clears it.
  assign keep_inc = s_axis_tkeep + {{(DATA_BYTES-1){1'b0}}, 1'b1};
  assign keep_bad = s_axis_tlast
                  ? ((s_axis_tkeep == '0) ||
                     ((s_axis_tkeep & keep_inc) != '0))
                  : (s_axis_tkeep != KEEP_ALL);

  assign new_ent = {ovf_q | sum_ovf, err_q | keep_bad, len_sat};

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;

    if (main_free) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d     = in_beat;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = in_beat;
      skid_vld_d = 1'b1;
    end
  end

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    err_d = err_q;
    if (accept) begin
      if (s_axis_tlast) begin
        acc_d = '0;
        ovf_d = 1'b0;
        err_d = 1'b0;
      end else begin
        acc_d = len_sat;
        ovf_d = ovf_q | sum_ovf;
        err_d = err_q | keep_bad;
      end
    end
  end

  always_comb begin
    head_d     = head_q;
    head_vld_d = head_vld_q;
    tail_d     = tail_q;
    tail_vld_d = tail_vld_q;

    if (pop) begin
      if (tail_vld_q) begin
        head_d = tail_q;
        if (push)
          tail_d = new_ent;
        else
          tail_vld_d = 1'b0;
      end else if (push) begin
        head_d = new_ent;
      end else begin
        head_vld_d = 1'b0;
      end
    end else if (push) begin
      if (head_vld_q) begin
        tail_d     = new_ent;
        tail_vld_d = 1'b1;
      end else begin
        head_d     = new_ent;
        head_vld_d = 1'b1;
      end
    end
  end

  // Ready is precomputed from next state so it leaves a flop directly.
  assign rdy_d = !skid_vld_d && !tail_vld_d;

  always_ff @(posedge aclk) begin
    if (areset) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      head_q     <= '0;
      head_vld_q <= 1'b0;
      tail_q     <= '0;
      tail_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
      tail_q     <= tail_d;
      tail_vld_q <= tail_vld_d;
    end
  end

  assign s_axis_tready = rdy_q;
  assign m_axis_tdata  = main_q[BW-1 -: DW];
  assign m_axis_tkeep  = main_q[DATA_BYTES:1];
  assign m_axis_tlast  = main_q[0];
  assign m_axis_tvalid = main_vld_q;
  assign m_len_tdata   = head_q[LEN_W-1:0];
  assign m_len_tuser   = head_q[EW-1:LEN_W];
  assign m_len_tvalid  = head_vld_q;

endmodule

// File: doc/axis_pkt_len_tagger.md
Name: axis_pkt_len_tagger

Overview:
- Sits directly downstream of the 8-to-32-bit AXI4-Stream width converter and consumes its 32-bit output stream (tdata/tkeep/tlast).
- Passes every beat through unchanged via a full-throughput registered skid buffer.
- Counts the valid bytes in each packet and, on each tlast, emits that packet's byte length plus error flags on a separate AXI4-Stream length channel. Downstream framers and DMA descriptor logic read packet sizes from this channel without re-scanning the data.

Parameters:
- DATA_BYTES, 4, bytes per data beat; tdata width = 8*DATA_BYTES, tkeep width = DATA_BYTES.
- LEN_W, 16, width of the packet length field.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  8*DATA_BYTES  input data.
- s_axis_tkeep  in  DATA_BYTES  input byte qualifiers.
- s_axis_tlast  in  1  end of packet.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready; registered.
- m_axis_tdata  out  8*DATA_BYTES  output data; registered.
- m_axis_tkeep  out  DATA_BYTES  output keep; registered.
- m_axis_tlast  out  1  output last; registered.
- m_axis_tvalid  out  1  output valid; registered.
- m_axis_tready  in  1  output ready.
- m_len_tdata  out  LEN_W  packet byte count.
- m_len_tuser  out  2  bit0 = keep error, bit1 = length overflow.
- m_len_tvalid  out  1  length entry valid.
- m_len_tready  in  1  length consumer ready.

Behaviour:
- Reset (areset=1 at a clock edge):
  - s_axis_tready=0, m_axis_tvalid=0, m_len_tvalid=0.
  - m_axis_tdata/tkeep/tlast=0, m_len_tdata=0, m_len_tuser=0.
  - Byte accumulator and sticky error cleared; length FIFO emptied; skid buffer emptied.
  - s_axis_tready rises in the first cycle after areset deasserts.
- Reset mid-packet: the partial packet and all buffered beats and lengths are discarded. No length entry is emitted for the partial packet.
- Data path, two-entry skid buffer (main output register + skid register):
  - Latency: 1 cycle from input acceptance to m_axis_tvalid.
  - Sustains 1 beat/cycle when m_axis_tready=1.
  - A beat moves into the skid register only when main holds data and m_axis_tready=0.
  - tdata/tkeep/tlast are passed through bit-exact; the block never drops or reorders beats.
  - m_axis_* stays stable while tvalid=1 and tready=0.
- s_axis_tready = (skid register empty) AND (length FIFO count < 2), computed from registered state only. It has no combinational path from m_axis_tready or m_len_tready.
- Acceptance: a beat is accepted when s_axis_tvalid && s_axis_tready.
- Byte counting, for each accepted beat:
  - pc = popcount(s_axis_tkeep).
  - Non-last beat: acc += pc.
  - Last beat: length = acc + pc is pushed to the FIFO, then acc is cleared.
  - Arithmetic is LEN_W+1 wide. A result above 2^LEN_W-1 saturates to 2^LEN_W-1 and sets the overflow flag for that packet. Once saturated, acc stays saturated until tlast.
- Keep checking:
  - Non-last beats must have tkeep all ones.
  - Last beats must have contiguous ones from the LSB, nonzero (1,3,7,F for 4 bytes).
  - Any violation sets a sticky per-packet error bit. That bit is reported in tuser[0] of the packet's entry and cleared after the push.
  - Bytes are still counted by popcount even when the error bit is set.
- Length FIFO:
  - Depth 2, in order; head drives m_len_*; registered outputs.
  - Push and pop in the same cycle are legal at any count, including count=2 (pop frees the slot; push is only possible when count<2 because of tready gating).
  - The FIFO never overflows; back-pressure from the length consumer eventually stalls s_axis.
- Simultaneous events:
  - A tlast push and an accumulator clear in the same cycle as a new packet's first beat cannot occur, because one beat is accepted per cycle.
  - A single-beat packet (tlast on the first beat) yields length = pc.
- No internal timeouts. The block does not modify tlast boundaries.

Test Plan:
- Post-reset idle: hold areset 5 cycles, then release -> s_axis_tready=1 from the next cycle; m_axis_tvalid=0, m_len_tvalid=0.
- Converter-style traffic, m_axis_tready=1 and m_len_tready=1:
  - Input: {0x03020100, keep F}, {0x00000004, keep 1, last}, {0x00070605, keep 7, last}.
  - Required: the same 3 beats appear on m_axis 1 cycle later, unchanged.
  - Required length entries: 5 with tuser=0, then 3 with tuser=0.
- Backpressure: m_axis_tready toggles 0/1 every cycle during a 16-beat keep-F packet -> all 16 beats arrive in order with no duplicates; single length entry 64; s_axis_tready never asserts while the skid register is full.
- Length stall: m_len_tready=0 with four single-beat keep-F packets -> two entries of 4 are held; s_axis_tready falls after the 2nd tlast. Raising m_len_tready drains the entries and the remaining packets are then accepted, giving four length entries of 4 in total.
- Errors:
  - Packet {keep 3, non-last}, {keep F, last} -> length 6, tuser=01.
  - With LEN_W=4, a 5-beat keep-F packet -> length 15, tuser=10.
- Mid-packet reset: after 2 beats of a 4-beat packet, pulse areset for 1 cycle and then send a fresh {keep 1, last} packet -> the only length entry is 1; no stale beats appear on m_axis.
